sub32_seq: RTL

Multi-cycle 32-bit subtractor: computes a − b − bi one byte per cycle (least-significant byte first) through a single 8-bit borrow-chained slice. It returns unsigned borrow, signed overflow and zero flags. It is the inverse-direction companion to the 32-bit carry-lookahead adder in the arithmetic library, with a start/done handshake for sequential datapaths. It also gives area-constrained designs a subtract path without a second 32-bit adder.

---
 rtl/sub32_seq_if.sv | 24 ++
 rtl/sub32_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/sub32_seq_if.sv
// Request/result bundle for the byte-serial 32-bit subtractor.
// The master drives the operands and start; the slave returns the result and flags.
interface sub32_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo, ovf, zero
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo, ovf, zero
    );
endinterface

// File: rtl/sub32_seq.sv
// Multi-cycle 32-bit subtractor: a - b - bi, one byte per cycle, LSB first,
// through a single 8-bit borrow-chained slice, with borrow/overflow/zero flags.
module sub32_seq (
    input  logic        clk,
    input  logic        reset,
    sub32_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic [31:0] d_reg, d_next;
    logic        borrow, borrow_next;
    logic        bo_reg, bo_next;
    logic        ovf_reg, ovf_next;
    logic        zero_reg, zero_next;

    logic [4:0]  base;
    logic [8:0]  slice;
    logic [31:0] d_slice;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            a_reg    <= 32'h0;
            b_reg    <= 32'h0;
            d_reg    <= 32'h0;
            borrow   <= 1'b0;
            bo_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            d_reg    <= d_next;
            borrow   <= borrow_next;
            bo_reg   <= bo_next;
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
        end
    end

    // Flags are computed from d with the final byte merged in, so they land on
    // the same edge as the last byte rather than one cycle later.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        a_next      = a_reg;
        b_next      = b_reg;
        d_next      = d_reg;
        borrow_next = borrow;
        bo_next     = bo_reg;
        ovf_next    = ovf_reg;
        zero_next   = zero_reg;

        base    = {cnt, 3'b000};
        slice   = {1'b0, a_reg[base +: 8]} - {1'b0, b_reg[base +: 8]} - {8'b0, borrow};
        d_slice = d_reg;
        d_slice[base +: 8] = slice[7:0];

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_next      = bus.a;
                    b_next      = bus.b;
                    borrow_next = bus.bi;
                    d_next      = 32'h0;
                    cnt_next    = 2'd0;
                    state_next  = RUN;
                end else begin
                    state_next  = IDLE;
                end
            end
            RUN: begin
                d_next      = d_slice;
                borrow_next = slice[8];
                cnt_next    = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_next = DONE;
                    bo_next    = slice[8];
                    ovf_next   = (a_reg[31] ^ b_reg[31]) & (d_slice[31] ^ a_reg[31]);
                    zero_next  = (d_slice == 32'h0);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.d    = d_reg;
    assign bus.bo   = bo_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.zero = zero_reg;
endmodule
